act_pingpong_buffer: RTL

Downstream neighbour of the processing unit. It captures the serial 8-bit activation stream a layer's PU emits (one byte per valid cycle) into a two-bank ping-pong buffer. It then replays each completed bank, one byte per cycle, as the `din`/`mac_en` stream for the next layer's PU, and finishes each replay with a `relu_en` pulse that triggers that PU's readout. Because the banks alternate, layer N+1 can consume frame k while layer N produces frame k+1.

---
 rtl/act_pingpong_buffer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/act_pingpong_buffer.sv
// act_pingpong_buffer: captures a serial activation stream into one of two banks
// and replays each completed bank to the next layer's PU as a din/mac_en burst
// followed by a single relu_en pulse.
// Optional feature macro: ACT_BUF_RELU_CLAMP_EN (negative activations stored as 0).
module act_pingpong_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 128,
  parameter int ADDR_WIDTH   = 7,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_valid_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_done_i,
  input  logic                  rd_ready_i,
  output logic                  mac_en_o,
  output logic [DATA_WIDTH-1:0] din_o,
  output logic                  relu_en_o,
  output logic                  busy_o,
  output logic                  overflow_o,
  output logic                  frame_err_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR   = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [15:0]           DRAIN_LAST = 16'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FIRE} state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   mem [2][DEPTH];
  logic [1:0]              bank_full;
  logic                    wr_bank, rd_bank;
  logic [ADDR_WIDTH-1:0]   wr_ptr, rd_ptr, rd_ptr_next;
  logic [15:0]             drain_cnt, drain_next;
  logic                    wr_accept, wr_last, frame_abort, bank_release;
  logic [DATA_WIDTH-1:0]   wr_store;

`ifdef ACT_BUF_RELU_CLAMP_EN
  assign wr_store = wr_data_i[DATA_WIDTH-1] ? '0 : wr_data_i;
`else
  assign wr_store = wr_data_i;
`endif

  // A write lands only when the current write bank is still free; the last
  // entry closes the frame, and a done pulse on a partial frame discards it.
  always_comb begin
    wr_accept   = wr_valid_i && !bank_full[wr_bank];
    wr_last     = wr_accept && (wr_ptr == LAST_PTR);
    frame_abort = wr_done_i && !wr_last && (wr_accept || (wr_ptr != '0));
  end

  // Activation storage; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_accept) mem[wr_bank][wr_ptr] <= wr_store;
  end

  // Write-side bookkeeping: pointer, bank toggle, full flags and sticky errors.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_full   <= '0;
      wr_bank     <= 1'b0;
      wr_ptr      <= '0;
      overflow_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      if (bank_release) bank_full[rd_bank] <= 1'b0;
      if (wr_valid_i && bank_full[wr_bank]) overflow_o <= 1'b1;
      if (wr_accept) begin
        if (wr_last) begin
          bank_full[wr_bank] <= 1'b1;
          wr_ptr             <= '0;
          wr_bank            <= ~wr_bank;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      if (frame_abort) begin
        frame_err_o <= 1'b1;
        wr_ptr      <= '0;
      end
    end
  end

  // Read FSM state register, including the bank swap on FIRE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      drain_cnt <= '0;
      rd_bank   <= 1'b0;
    end else begin
      state     <= state_next;
      rd_ptr    <= rd_ptr_next;
      drain_cnt <= drain_next;
      if (state == FIRE) rd_bank <= ~rd_bank;
    end
  end

  // Read FSM next-state: rd_ptr is the entry presented in the current STREAM cycle.
  always_comb begin
    state_next  = state;
    rd_ptr_next = rd_ptr;
    drain_next  = drain_cnt;
    case (state)
      IDLE: begin
        if (bank_full[rd_bank] && rd_ready_i) begin
          state_next  = STREAM;
          rd_ptr_next = '0;
        end
      end
      STREAM: begin
        if (rd_ptr == LAST_PTR) begin
          rd_ptr_next = '0;
          drain_next  = '0;
          state_next  = (DRAIN_CYCLES == 0) ? FIRE : DRAIN;
        end else begin
          rd_ptr_next = rd_ptr + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_next = FIRE;
        else                         drain_next = drain_cnt + 16'd1;
      end
      FIRE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read FSM outputs decoded directly from the registered state.
  always_comb begin
    relu_en_o    = (state == FIRE);
    busy_o       = (state != IDLE);
    bank_release = (state == FIRE);
  end

  // Registered read port: mac_en and din are launched from the next state so
  // both appear together in every STREAM cycle and are zero otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mac_en_o <= 1'b0;
      din_o    <= '0;
    end else if (state_next == STREAM) begin
      mac_en_o <= 1'b1;
      din_o    <= mem[rd_bank][rd_ptr_next];
    end else begin
      mac_en_o <= 1'b0;
      din_o    <= '0;
    end
  end

endmodule
